// File: rtl/wide_alu_seq_pkg.sv
// Shared definitions for the wide ALU sequencer: 8-bit ALU opcodes, wide op codes, FSM states.
package wide_alu_seq_pkg;

    localparam int unsigned ALU_CTRL_W = 4;

    localparam logic [ALU_CTRL_W-1:0] kAdd  = 4'h0;
    localparam logic [ALU_CTRL_W-1:0] kAddC = 4'h1;
    localparam logic [ALU_CTRL_W-1:0] kAnd  = 4'h4;
    localparam logic [ALU_CTRL_W-1:0] kOr   = 4'h5;

    typedef enum logic [1:0] {
        kWAdd = 2'd0,
        kWSub = 2'd1,
        kWAnd = 2'd2,
        kWOr  = 2'd3
    } wide_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Add and subtract propagate a carry between bytes; logic ops do not.
    function automatic logic is_arith(wide_op_t op);
        return (op == kWAdd) || (op == kWSub);
    endfunction

endpackage

// File: rtl/wide_alu_seq.sv
// Runs NBYTES-wide add/sub/and/or through an external 8-bit ALU, one byte per cycle, LSB first.
module wide_alu_seq
    import wide_alu_seq_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [8*NBYTES-1:0] req_a,
    input  logic [8*NBYTES-1:0] req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [8*NBYTES-1:0] rsp_result,
    output logic                rsp_cout,
    output logic                rsp_zero,
    output logic [3:0]          alu_ctrl,
    output logic [7:0]          alu_a,
    output logic [7:0]          alu_b,
    output logic                alu_cin,
    input  logic [7:0]          alu_out,
    input  logic                alu_cout,
    input  logic                alu_zero
);

    localparam int unsigned W     = 8 * NBYTES;
    localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    seq_state_t       state;
    seq_state_t       state_nxt;
    wide_op_t         op_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     result_q;
    logic [IDX_W-1:0] idx;
    logic             carry_q;
    logic             zacc_q;
    logic [7:0]       a_byte;
    logic [7:0]       b_byte;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (req_valid)        state_nxt = RUN;
            RUN:     if (idx == LAST_IDX)  state_nxt = DONE;
            DONE:    if (rsp_ready)        state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    assign req_ready  = (state == IDLE);
    assign rsp_valid  = (state == DONE);
    assign rsp_result = result_q;
    assign rsp_cout   = carry_q;
    assign rsp_zero   = zacc_q;

    // Select the operand bytes addressed by idx
    always_comb begin
        a_byte = 8'h00;
        b_byte = 8'h00;
        for (int unsigned k = 0; k < NBYTES; k++) begin
            if (idx == IDX_W'(k)) begin
                a_byte = a_q[8*k +: 8];
                b_byte = b_q[8*k +: 8];
            end
        end
    end

    // ALU drive; parked on a zero add whenever no byte is in flight
    always_comb begin
        alu_ctrl = kAdd;
        alu_a    = 8'h00;
        alu_b    = 8'h00;
        alu_cin  = 1'b0;
        if (state == RUN) begin
            alu_a = a_byte;
            unique case (op_q)
                kWAdd: begin
                    alu_ctrl = kAddC;
                    alu_b    = b_byte;
                    alu_cin  = carry_q;
                end
                kWSub: begin
                    alu_ctrl = kAddC;
                    alu_b    = ~b_byte;
                    alu_cin  = carry_q;
                end
                kWAnd: begin
                    alu_ctrl = kAnd;
                    alu_b    = b_byte;
                end
                kWOr: begin
                    alu_ctrl = kOr;
                    alu_b    = b_byte;
                end
                default: ;
            endcase
        end
    end

    // Operand latch and per-byte accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= kWAdd;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx      <= '0;
            carry_q  <= 1'b0;
            zacc_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q    <= wide_op_t'(req_op);
                        a_q     <= req_a;
                        b_q     <= req_b;
                        idx     <= '0;
                        zacc_q  <= 1'b1;
                        // Subtract seeds the chain with the +1 of two's complement
                        carry_q <= (wide_op_t'(req_op) == kWSub);
                    end
                end
                RUN: begin
                    for (int unsigned k = 0; k < NBYTES; k++) begin
                        if (idx == IDX_W'(k)) begin
                            result_q[8*k +: 8] <= alu_out;
                        end
                    end
                    carry_q <= is_arith(op_q) ? alu_cout : 1'b0;
                    zacc_q  <= zacc_q & alu_zero;
                    if (idx != LAST_IDX) begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wide_alu_seq.sv
// Bench for wide_alu_seq: 4-byte and 2-byte instances, each wired to a behavioural 8-bit ALU.
module tb_wide_alu_seq;
    import wide_alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_ready;

    logic        rr4, rv4, co4, z4, cin4, ac4, az4;
    logic [31:0] res4;
    logic [3:0]  ctrl4;
    logic [7:0]  a4, b4, ao4;
    logic        rr2, rv2, co2, z2, cin2, ac2, az2;
    logic [15:0] res2;
    logic [3:0]  ctrl2;
    logic [7:0]  a2, b2, ao2;

    logic        v_req_ready, v_rsp_valid, v_cout, v_zero, v_alu_cin;
    logic [31:0] v_result;
    logic [3:0]  v_alu_ctrl;
    logic [7:0]  v_alu_a, v_alu_b;

    int n_vec = 0;
    int n_bad = 0;

    logic [3:0] seen_ctrl[8];
    logic [7:0] seen_a[8];
    logic [7:0] seen_b[8];
    logic       seen_cin[8];

    always #5 clk = ~clk;

    wide_alu_seq #(.NBYTES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid & ~sel), .req_ready(rr4), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rv4), .rsp_ready(rsp_ready & ~sel), .rsp_result(res4),
        .rsp_cout(co4), .rsp_zero(z4),
        .alu_ctrl(ctrl4), .alu_a(a4), .alu_b(b4), .alu_cin(cin4),
        .alu_out(ao4), .alu_cout(ac4), .alu_zero(az4)
    );

    wide_alu_seq #(.NBYTES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid & sel), .req_ready(rr2), .req_op(req_op),
        .req_a(req_a[15:0]), .req_b(req_b[15:0]),
        .rsp_valid(rv2), .rsp_ready(rsp_ready & sel), .rsp_result(res2),
        .rsp_cout(co2), .rsp_zero(z2),
        .alu_ctrl(ctrl2), .alu_a(a2), .alu_b(b2), .alu_cin(cin2),
        .alu_out(ao2), .alu_cout(ac2), .alu_zero(az2)
    );

    // Behavioural 8-bit ALU: returns {zero, cout, out}
    function automatic logic [9:0] alu_fn(logic [3:0] c, logic [7:0] a, logic [7:0] b, logic cin);
        logic [8:0] s;
        case (c)
            kAdd:    s = {1'b0, a} + {1'b0, b};
            kAddC:   s = {1'b0, a} + {1'b0, b} + 9'(cin);
            kAnd:    s = {1'b0, a & b};
            kOr:     s = {1'b0, a | b};
            default: s = 9'h000;
        endcase
        return {s[7:0] == 8'h00, s[8], s[7:0]};
    endfunction

    assign {az4, ac4, ao4} = alu_fn(ctrl4, a4, b4, cin4);
    assign {az2, ac2, ao2} = alu_fn(ctrl2, a2, b2, cin2);

    assign v_req_ready = sel ? rr2 : rr4;
    assign v_rsp_valid = sel ? rv2 : rv4;
    assign v_result    = sel ? {16'h0000, res2} : res4;
    assign v_cout      = sel ? co2 : co4;
    assign v_zero      = sel ? z2 : z4;
    assign v_alu_ctrl  = sel ? ctrl2 : ctrl4;
    assign v_alu_a     = sel ? a2 : a4;
    assign v_alu_b     = sel ? b2 : b4;
    assign v_alu_cin   = sel ? cin2 : cin4;

    // Reference: whole-word arithmetic on nb bytes; returns {zero, cout, result}
    function automatic logic [33:0] ref_op(logic [1:0] op, logic [31:0] a, logic [31:0] b, int nb);
        logic [63:0] m, aa, bb, r;
        logic        c;
        m  = (64'd1 << (8 * nb)) - 64'd1;
        aa = {32'h0, a} & m;
        bb = {32'h0, b} & m;
        case (op)
            2'd0:    begin r = aa + bb; c = r[8*nb]; r = r & m; end
            2'd1:    begin r = (aa - bb) & m; c = (aa >= bb); end
            2'd2:    begin r = aa & bb; c = 1'b0; end
            default: begin r = aa | bb; c = 1'b0; end
        endcase
        return {r == 64'h0, c, r[31:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        check("req_ready_idle", 64'(v_req_ready), 64'h1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
    endtask

    // Returns edges from accept until rsp_valid is seen; records the per-byte ALU drive
    task automatic wait_rsp(input bit busy, output int lat);
        lat = -1;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (n == 1) req_valid = 1'b0;
            if (busy && n == 2) begin
                req_valid = 1'b1;
                req_op    = ~req_op;
                req_a     = ~req_a;
            end
            if (busy && n == 3) req_valid = 1'b0;
            if (v_rsp_valid) begin
                lat = n - 1;
                break;
            end
            if (n <= 8) begin
                seen_ctrl[n-1] = v_alu_ctrl;
                seen_a[n-1]    = v_alu_a;
                seen_b[n-1]    = v_alu_b;
                seen_cin[n-1]  = v_alu_cin;
            end
            check("busy_req_ready", 64'(v_req_ready), 64'h0);
        end
        if (lat < 0) check("rsp_timeout", 64'(v_rsp_valid), 64'h1);
    endtask

    task automatic verify_drive(input string tag, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input int nb);
        logic [3:0] ec;
        logic [7:0] eb;
        ec = (op == kWAnd) ? kAnd : (op == kWOr) ? kOr : kAddC;
        for (int k = 0; k < nb; k++) begin
            eb = b[8*k +: 8];
            if (op == kWSub) eb = ~eb;
            check({tag, "_alu_ctrl"}, 64'(seen_ctrl[k]), 64'(ec));
            check({tag, "_alu_a"}, 64'(seen_a[k]), 64'(a[8*k +: 8]));
            check({tag, "_alu_b"}, 64'(seen_b[k]), 64'(eb));
        end
        check({tag, "_alu_cin0"}, 64'(seen_cin[0]), 64'(op == kWSub));
    endtask

    task automatic check_rsp(input string tag, input logic [31:0] er, input logic ec, input logic ez);
        check({tag, "_rsp_valid"}, 64'(v_rsp_valid), 64'h1);
        check({tag, "_rsp_result"}, 64'(v_result), 64'(er));
        check({tag, "_rsp_cout"}, 64'(v_cout), 64'(ec));
        check({tag, "_rsp_zero"}, 64'(v_zero), 64'(ez));
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_post_valid"}, 64'(v_rsp_valid), 64'h0);
        check({tag, "_post_ready"}, 64'(v_req_ready), 64'h1);
    endtask

    task automatic do_vec(input string tag, input logic s, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                          input logic ec, input logic ez, input int elat, input int hold,
                          input bit busy);
        int lat;
        sel = s;
        start_req(op, a, b);
        wait_rsp(busy, lat);
        check({tag, "_latency"}, 64'(lat), 64'(elat));
        if (lat >= 0) begin
            verify_drive(tag, op, a, b, s ? 2 : 4);
            check_rsp(tag, er, ec, ez);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check_rsp({tag, "_hold"}, er, ec, ez);
                check({tag, "_hold_ready"}, 64'(v_req_ready), 64'h0);
            end
            handshake(tag);
        end
    endtask

    typedef struct {
        logic        s;
        logic [1:0]  op;
        logic [31:0] a, b, res;
        logic        cout, zero;
        int          lat;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        bit          saw_valid;
        logic [33:0] r;
        logic [1:0]  op;
        logic [31:0] a, b;
        logic        s;

        tbl[0] = '{1'b0, kWAdd, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 4};
        tbl[1] = '{1'b0, kWSub, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 4};
        tbl[2] = '{1'b0, kWSub, 32'h1234_5678, 32'h0000_5678, 32'h1234_0000, 1'b1, 1'b0, 4};
        tbl[3] = '{1'b0, kWAnd, 32'hF0F0_A5A5, 32'hFF00_FF00, 32'hF000_A500, 1'b0, 1'b0, 4};
        tbl[4] = '{1'b0, kWOr,  32'hF0F0_A5A5, 32'hFF00_FF00, 32'hFFF0_FFA5, 1'b0, 1'b0, 4};
        tbl[5] = '{1'b0, kWSub, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 1'b1, 4};
        tbl[6] = '{1'b1, kWAdd, 32'h0000_80FF, 32'h0000_8001, 32'h0000_0100, 1'b1, 1'b0, 2};

        rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0; req_op = 2'd0;
        req_a = 32'h0; req_b = 32'h0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 64'(v_rsp_valid), 64'h0);
        check("rst_req_ready", 64'(v_req_ready), 64'h1);
        check("rst_result", 64'(v_result), 64'h0);
        check("rst_cout", 64'(v_cout), 64'h0);
        check("rst_zero", 64'(v_zero), 64'h0);
        check("rst_alu_ctrl", 64'(v_alu_ctrl), 64'(kAdd));
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_vec($sformatf("tbl%0d", i), tbl[i].s, tbl[i].op, tbl[i].a, tbl[i].b,
                   tbl[i].res, tbl[i].cout, tbl[i].zero, tbl[i].lat, 0, 1'b0);
        end

        // Busy pulse in RUN, queued request during 5-cycle backpressure
        sel = 1'b0;
        start_req(kWAdd, 32'h1111_1111, 32'h2222_2222);
        wait_rsp(1'b1, lat);
        check("bp_latency", 64'(lat), 64'd4);
        check_rsp("bp", 32'h3333_3333, 1'b0, 1'b0);
        req_valid = 1'b1; req_op = kWOr; req_a = 32'h0000_000F; req_b = 32'h0000_00F0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_rsp("bp_hold", 32'h3333_3333, 1'b0, 1'b0);
            check("bp_hold_ready", 64'(v_req_ready), 64'h0);
        end
        handshake("bp");
        wait_rsp(1'b0, lat);
        check("bp_next_latency", 64'(lat), 64'd4);
        check_rsp("bp_next", 32'h0000_00FF, 1'b0, 1'b0);
        handshake("bp_next");

        // Reset in the second RUN cycle aborts with no response
        sel = 1'b0;
        start_req(kWAdd, 32'hFFFF_FFFF, 32'h0000_00FF);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(v_rsp_valid), 64'h0);
        check("mid_rst_ready", 64'(v_req_ready), 64'h1);
        check("mid_rst_result", 64'(v_result), 64'h0);
        check("mid_rst_cout", 64'(v_cout), 64'h0);
        check("mid_rst_zero", 64'(v_zero), 64'h0);
        check("mid_rst_alu_ctrl", 64'(v_alu_ctrl), 64'(kAdd));
        check("mid_rst_alu_a", 64'(v_alu_a), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (v_rsp_valid) saw_valid = 1'b1;
        end
        check("mid_rst_no_rsp", 64'(saw_valid), 64'h0);
        do_vec("post_rst", 1'b0, kWAdd, 32'h1, 32'h1, 32'h2, 1'b0, 1'b0, 4, 0, 1'b0);

        // Random operations against the reference model
        for (int i = 0; i < 60; i++) begin
            s  = (i % 3 == 2);
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if (i % 7 == 0) b = a;
            if (i % 7 == 3) b = ~a;
            r = ref_op(op, a, b, s ? 2 : 4);
            do_vec($sformatf("rnd%0d", i), s, op, a, b, r[31:0], r[32], r[33],
                   s ? 2 : 4, int'($urandom_range(0, 2)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
